// File: rtl/fader_pkg.sv
// Shared widths, types and helpers for the fader gain path.
package fader_pkg;

    localparam int FADER_CNT_W  = 22;
    localparam int FADER_DATA_W = 16;
    localparam int FADER_GAIN_W = 16;
    localparam int FADER_PROD_W = FADER_DATA_W + FADER_GAIN_W + 1;

    typedef logic signed [FADER_DATA_W-1:0] sample_t;
    typedef logic        [FADER_GAIN_W-1:0] gain_t;
    typedef logic        [FADER_CNT_W-1:0]  count_t;

    // An all-ones gain is treated as exactly 1.0 rather than 1 - 2**-GAIN_W.
    function automatic logic unity_gain(input gain_t gain);
        return &gain;
    endfunction

endpackage

// File: rtl/fader_scale.sv
// Combinational gain extraction and sample scaling for the fader gain stage.
// Rounding mode selected by FADER_ROUND_EN (defined: round half up, undefined: floor).
module fader_scale
    import fader_pkg::*;
(
    input  count_t  count,
    input  logic    enable,
    input  sample_t sample,
    output sample_t result
);

    typedef logic signed [FADER_PROD_W-1:0] prod_t;

    gain_t gain;
    prod_t prod;
    prod_t biased;
    logic  unused_count_lsbs;

    assign gain              = count[FADER_CNT_W-1 -: FADER_GAIN_W];
    assign unused_count_lsbs = ^count[FADER_CNT_W-FADER_GAIN_W-1:0];

    // Gain is an unsigned fraction, so it is zero-extended while the sample is sign-extended.
    assign prod = {{(FADER_GAIN_W+1){sample[FADER_DATA_W-1]}}, sample}
                * {{FADER_DATA_W{1'b0}}, 1'b0, gain};

`ifdef FADER_ROUND_EN
    localparam prod_t ROUND_BIAS = prod_t'(2 ** (FADER_GAIN_W - 1));
    assign biased = prod + ROUND_BIAS;
`else
    assign biased = prod;
`endif

    assign result = (enable && !unity_gain(gain))
                  ? sample_t'(biased >>> FADER_GAIN_W)
                  : sample;

endmodule

// File: rtl/fader_gain_stage.sv
// Two-stage valid/ready pipeline applying the fader envelope to PCM samples.
// Optional FADER_ROUND_EN selects rounding in fader_scale instead of floor.
module fader_gain_stage
    import fader_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    clear,
    input  logic                    fad_enable,
    input  logic [FADER_CNT_W-1:0]  count_val,
    input  logic                    in_valid,
    input  logic [FADER_DATA_W-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [FADER_DATA_W-1:0] out_data,
    input  logic                    out_ready,
    output logic                    busy
);

    logic    adv;
    logic    s1_valid;
    sample_t s1_data;
    count_t  s1_count;
    logic    s1_enable;
    logic    s2_valid;
    sample_t s2_data;
    sample_t scaled;

    assign adv       = !s2_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign busy      = s1_valid || s2_valid;

    fader_scale u_scale (
        .count  (s1_count),
        .enable (s1_enable),
        .sample (s1_data),
        .result (scaled)
    );

    // The count snapshot is taken at acceptance so later fader movement cannot touch a queued sample.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_count  <= '0;
            s1_enable <= 1'b0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
        end else begin
            if (clear) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else if (adv) begin
                s1_valid <= in_valid;
                s2_valid <= s1_valid;
            end
            if (adv && in_valid) begin
                s1_data   <= sample_t'(in_data);
                s1_count  <= count_val;
                s1_enable <= fad_enable;
            end
            if (adv && s1_valid && !clear) begin
                s2_data <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_fader_gain_stage.sv
// Self-checking bench for fader_gain_stage: directed steps plus randomized traffic against a queue model.
module tb_fader_gain_stage;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        clear = 1'b0;
    logic        fad_enable = 1'b0;
    logic [21:0] count_val = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;

    int passed = 0;
    int total = 0;
    int failed = 0;
    int out_count = 0;

    logic [15:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic        prev_clear = 1'b0;
    logic [15:0] prev_data = '0;

    fader_gain_stage dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .clear      (clear),
        .fad_enable (fad_enable),
        .count_val  (count_val),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Reference: gain is the top 16 bits of the count as a fraction of 65536; all-ones or disabled means 1.0.
    function automatic logic [15:0] model(input logic [15:0] x, input logic [21:0] cnt, input logic en);
        longint s, g, p;
        s = longint'($signed(x));
        g = longint'(cnt >> 6);
        if (!en || g == 65535) return x;
        p = s * g;
`ifdef FADER_ROUND_EN
        p = p + 32768;
`endif
        p = p >>> 16;
        return p[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, update the model, then settle past the rising edge.
    task automatic step();
        logic [15:0] exp;
        @(negedge clk);
        checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
        checkOutput("busy", busy, exp_q.size() != 0);
        if (prev_stall && !prev_clear) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
                checkOutput("out_spurious", out_valid, 0);
            end else begin
                exp = exp_q.pop_front();
                checkOutput("out_data", out_data, exp);
            end
        end
        if (clear) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(model(in_data, count_val, fad_enable));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_clear = clear;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [21:0] cnt,
                                 input logic en, input logic rdy, input logic clr);
        in_valid   = v;
        in_data    = d;
        count_val  = cnt;
        fad_enable = en;
        out_ready  = rdy;
        clear      = clr;
        step();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checkOutput("drain_empty", exp_q.size(), 0);
    endtask

    logic [15:0] vals[8];
    int sent;
    int cyc;
    int base_count;
    logic acc;

    initial begin
        #2;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_busy", busy, 0);
        #10 n_reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Half gain on a positive sample, with the two-cycle latency observed.
        applyStimulus(1, 16'h4000, 22'h200000, 1, 1, 0);
        checkOutput("lat_n1_valid", out_valid, 0);
        applyStimulus(0, 16'h0000, 22'h000000, 1, 1, 0);
        checkOutput("lat_n2_valid", out_valid, 1);
        checkOutput("half_gain", out_data, 16'h2000);
        drain();

        // Negative one at half gain exposes the rounding mode.
        applyStimulus(1, 16'hFFFF, 22'h200000, 1, 1, 0);
        applyStimulus(0, 16'h0000, 22'h200000, 1, 1, 0);
`ifdef FADER_ROUND_EN
        checkOutput("neg_one_half", out_data, 16'h0000);
`else
        checkOutput("neg_one_half", out_data, 16'hFFFF);
`endif
        drain();

        // Unity by full-scale count, then unity by disabling the envelope.
        applyStimulus(1, 16'h7FFF, 22'h3FFFFF, 1, 1, 0);
        applyStimulus(1, 16'h8000, 22'h000000, 0, 1, 0);
        checkOutput("unity_full", out_data, 16'h7FFF);
        applyStimulus(0, 16'h0000, 22'h000000, 0, 1, 0);
        checkOutput("unity_bypass", out_data, 16'h8000);
        drain();

        // Eight samples with a three-cycle downstream stall in the middle.
        for (int i = 0; i < 8; i++) vals[i] = 16'(16'h1111 * (i + 1));
        base_count = out_count;
        sent = 0;
        cyc = 0;
        while (sent < 8 && cyc < 40) begin
            in_valid   = 1'b1;
            in_data    = vals[sent];
            count_val  = 22'h3FFFFF;
            fad_enable = 1'b1;
            clear      = 1'b0;
            out_ready  = !(cyc >= 3 && cyc < 6);
            #1;
            acc = in_ready;
            if (cyc == 4) checkOutput("stall_in_ready", in_ready, 0);
            step();
            if (acc) sent++;
            cyc++;
        end
        checkOutput("stream_sent", sent, 8);
        drain();
        checkOutput("stream_out_count", out_count - base_count, 8);

        // Count changes after acceptance must not affect the accepted sample.
        applyStimulus(1, 16'h4000, 22'h100000, 1, 1, 0);
        applyStimulus(0, 16'h0000, 22'h3FFFFE, 1, 1, 0);
        checkOutput("gain_snapshot", out_data, 16'h1000);
        drain();

        // Clear with two samples in flight while downstream is stalled.
        applyStimulus(1, 16'h1234, 22'h300000, 1, 0, 0);
        applyStimulus(1, 16'h5678, 22'h300000, 1, 0, 0);
        checkOutput("pre_clear_busy", busy, 1);
        applyStimulus(1, 16'h9ABC, 22'h300000, 1, 0, 1);
        checkOutput("clear_valid", out_valid, 0);
        checkOutput("clear_busy", busy, 0);
        // Clear must also beat an accept on an empty pipeline.
        applyStimulus(1, 16'h1111, 22'h300000, 1, 1, 1);
        checkOutput("clear_wins_busy", busy, 0);
        applyStimulus(0, 16'h0000, 22'h300000, 1, 1, 0);
        checkOutput("clear_wins_valid", out_valid, 0);

        // Asynchronous reset in the middle of a stream.
        applyStimulus(1, 16'h2222, 22'h2AAAAA, 1, 1, 0);
        applyStimulus(1, 16'h3333, 22'h2AAAAA, 1, 1, 0);
        in_valid = 1'b0;
        #1 n_reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_data", out_data, 0);
        checkOutput("midrst_busy", busy, 0);
        exp_q.delete();
        prev_stall = 1'b0;
        #1 n_reset = 1'b1;
        #1;
        checkOutput("midrst_in_ready", in_ready, 1);
        step();

        // Randomized traffic checked against the queue model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          16'($urandom),
                          ($urandom_range(0, 7) == 0) ? 22'h3FFFFF : 22'($urandom),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 31) == 0);
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
